// File: rtl/rf_gpio_write_handshake_pkg.sv
// Shared GPIO field map, default widths and FSM state encoding for the
// GPIO-to-register-file write handshake.
package rf_pkg;
    localparam int REQ_BIT  = 31;
    localparam int ADDR_MSB = 30;
    localparam int ADDR_LSB = 22;
    localparam int DATA_MSB = 21;
    localparam int DATA_LSB = 0;

    localparam int NB_ADDR  = 9;
    localparam int NB_DATA  = 22;
    localparam int MAX_ADDR = 320;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'b0001,
        ST_LATCH    = 4'b0010,
        ST_STROBE   = 4'b0100,
        ST_WAIT_REL = 4'b1000
    } state_t;
endpackage

// File: rtl/rf_gpio_write_handshake_sync.sv
// Generic 2-flop single-bit synchronizer, async active-low reset.
// Only compiled when RF_GPIO_SYNC_EN is defined, the sole build that uses it.
`ifdef RF_GPIO_SYNC_EN
module rf_bit_sync (
    input  logic clock,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    logic meta;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end
endmodule
`endif

// File: rtl/rf_gpio_write_handshake.sv
// Converts the GPIO request level into one write strobe plus a 4-phase ack.
// Define RF_GPIO_SYNC_EN to pass the request bit through a 2-flop synchronizer.
module rf_gpio_write_handshake #(
    parameter int NB_GPIO        = 32,
    parameter int NB_ADDR        = rf_pkg::NB_ADDR,
    parameter int NB_DATA        = rf_pkg::NB_DATA,
    parameter int MAX_ADDR       = rf_pkg::MAX_ADDR,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int NB_TIMEOUT     = 16,
    parameter int NB_WR_COUNT    = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [NB_GPIO-1:0]     i_gpio_data,
    input  logic                   i_clear_err,
    output logic                   o_wr_strobe,
    output logic [NB_ADDR-1:0]     o_wr_addr,
    output logic [NB_DATA-1:0]     o_wr_data,
    output logic                   o_ack,
    output logic                   o_busy,
    output logic                   o_timeout_err,
    output logic                   o_bad_addr_err,
    output logic [NB_WR_COUNT-1:0] o_wr_count
);
    import rf_pkg::*;

    state_t                state, state_nxt;
    logic                  req;
    logic [NB_ADDR-1:0]    gpio_addr;
    logic [NB_DATA-1:0]    gpio_data;
    logic                  addr_ok;
    logic                  latch_en, tmo_clr, bad_set, tmo_set;
    logic [NB_TIMEOUT-1:0] tmo_cnt;

`ifdef RF_GPIO_SYNC_EN
    rf_bit_sync u_req_sync (
        .clock (i_clock),
        .rst_n (i_reset),
        .din   (i_gpio_data[REQ_BIT]),
        .dout  (req)
    );
`else
    assign req = i_gpio_data[REQ_BIT];
`endif

    // Address/data are taken straight from the GPIO word; software sets them
    // no later than the request, so they are stable by the LATCH cycle.
    assign gpio_addr = i_gpio_data[ADDR_MSB:ADDR_LSB];
    assign gpio_data = i_gpio_data[DATA_MSB:DATA_LSB];
    assign addr_ok   = int'(gpio_addr) < MAX_ADDR;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        o_wr_strobe = 1'b0;
        o_ack       = 1'b0;
        latch_en    = 1'b0;
        tmo_clr     = 1'b0;
        bad_set     = 1'b0;
        tmo_set     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                latch_en = 1'b1;
                tmo_clr  = 1'b1;
                if (addr_ok) begin
                    state_nxt = ST_STROBE;
                end else begin
                    bad_set   = 1'b1;
                    state_nxt = ST_WAIT_REL;
                end
            end
            ST_STROBE: begin
                o_wr_strobe = 1'b1;
                tmo_clr     = 1'b1;
                state_nxt   = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                o_ack = 1'b1;
                if (!req) state_nxt = ST_IDLE;
                // Fires once: the counter saturates at TIMEOUT_CYCLES.
                tmo_set = req && (tmo_cnt == NB_TIMEOUT'(TIMEOUT_CYCLES - 1));
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign o_busy = (state != ST_IDLE);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_wr_addr <= '0;
            o_wr_data <= '0;
        end else if (latch_en) begin
            o_wr_addr <= gpio_addr;
            o_wr_data <= gpio_data;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)                 o_wr_count <= '0;
        else if (o_wr_strobe)         o_wr_count <= o_wr_count + 1'b1;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)
            tmo_cnt <= '0;
        else if (tmo_clr)
            tmo_cnt <= '0;
        else if (state == ST_WAIT_REL && tmo_cnt != NB_TIMEOUT'(TIMEOUT_CYCLES))
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Sticky flags: a set in the same cycle as a clear takes priority.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_bad_addr_err <= 1'b0;
            o_timeout_err  <= 1'b0;
        end else begin
            if (bad_set)          o_bad_addr_err <= 1'b1;
            else if (i_clear_err) o_bad_addr_err <= 1'b0;
            if (tmo_set)          o_timeout_err  <= 1'b1;
            else if (i_clear_err) o_timeout_err  <= 1'b0;
        end
    end
endmodule

// File: doc/rf_gpio_write_handshake.md
Name: rf_gpio_write_handshake

Overview:
- Sits between the soft-core GPIO output word and the register-file write decoder.
- Turns the level-based request bit in the 32-bit GPIO word into a clean write transaction: one single-cycle write strobe with latched address and data.
- Returns a 4-phase acknowledge that is looped into the GPIO input word.
- Guards against stuck requests with a timeout and counts completed writes.

Parameters:
- NB_GPIO, 32, GPIO word width
- NB_ADDR, 9, address field width, GPIO[30:22]
- NB_DATA, 22, data field width, GPIO[21:0]
- MAX_ADDR, 320, first invalid address; writes at or above it are dropped
- TIMEOUT_CYCLES, 65535, max cycles in WAIT_REL before the timeout flag sets
- NB_TIMEOUT, 16, timeout counter width
- NB_WR_COUNT, 16, write counter width

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_gpio_data  in  NB_GPIO  GPIO word; bit 31 = request, [30:22] = addr, [21:0] = data
- i_clear_err  in  1  one-cycle pulse; clears sticky error flags
- o_wr_strobe  out  1  single-cycle write enable
- o_wr_addr  out  NB_ADDR  latched address, valid while o_wr_strobe = 1
- o_wr_data  out  NB_DATA  latched data, valid while o_wr_strobe = 1
- o_ack  out  1  acknowledge, looped back into the GPIO input word
- o_busy  out  1  high in any state other than IDLE
- o_timeout_err  out  1  sticky; request held for more than TIMEOUT_CYCLES
- o_bad_addr_err  out  1  sticky; request addressed at or above MAX_ADDR
- o_wr_count  out  NB_WR_COUNT  completed-write counter, wraps

Behaviour:
- Reset (i_reset = 0, asynchronous): state = IDLE; all outputs and counters = 0.
- req = i_gpio_data[31] (after the synchronizer when GPIO_SYNC_EN is defined).
- FSM states, one-hot: IDLE, LATCH, STROBE, WAIT_REL.
  - IDLE: req = 1 -> LATCH.
  - LATCH: capture addr/data from the GPIO word into holding registers.
    - addr < MAX_ADDR -> STROBE.
    - Otherwise set o_bad_addr_err -> WAIT_REL, with no strobe and no count increment.
  - STROBE: o_wr_strobe = 1 for exactly one cycle; o_wr_count += 1, modulo 2^NB_WR_COUNT -> WAIT_REL.
  - WAIT_REL: o_ack = 1.
    - req = 0 -> IDLE; o_ack drops on the following cycle.
    - Timeout counter increments every cycle spent here.
    - On reaching TIMEOUT_CYCLES: set o_timeout_err, saturate the counter, stay in WAIT_REL. The FSM never re-strobes without a release.
- Latency, no sync: req sampled high at cycle 0 -> LATCH cycle 1 -> strobe cycle 2 -> ack from cycle 3.
  - Release sampled at cycle k -> IDLE at k+1 -> next request accepted no earlier than k+1.
- o_wr_addr/o_wr_data hold their last latched value outside the strobe; they change only in LATCH.
- Data is captured one cycle after req is seen, so software sets addr/data no later than it raises req.
- Timeout counter clears on entry to WAIT_REL.
- i_clear_err clears both sticky flags.
  - Simultaneous set and clear: set wins.
  - Does not affect the FSM or o_wr_count.
- Request bit toggling within IDLE -> LATCH -> STROBE does not abort the write. It is only examined in IDLE and WAIT_REL.
- Reset mid-transaction: FSM returns to IDLE immediately; any pending strobe is lost.

Optional Feature:
- Macro: RF_GPIO_SYNC_EN.
- Defined:
  - req passes through a 2-flop synchronizer (reset to 0).
  - addr/data are captured from the GPIO word in LATCH, as without the macro.
  - Latency grows by 2 cycles: strobe at cycle 4, ack from cycle 5.
- Undefined: req is used directly; GPIO is same-clock.

Decomposition:
- Shared package rf_pkg holds:
  - GPIO field positions: REQ_BIT = 31, ADDR_MSB/LSB = 30/22, DATA_MSB/LSB = 21/0.
  - NB_ADDR, NB_DATA, MAX_ADDR.
  - State encoding constants.
- One sub-module is natural: rf_bit_sync, a generic 2-flop synchronizer with async active-low reset, instantiated only under RF_GPIO_SYNC_EN.

Test Plan:
- Basic write: GPIO = {1, addr = 9'd5, data = 22'h3A5A5} held for 10 cycles, then req = 0.
  - Expect exactly one o_wr_strobe at cycle 2 with addr 5 and data 0x3A5A5.
  - Expect o_ack high from cycle 3 until one cycle after release; o_wr_count = 1.
- Back-to-back: 3 writes, each released for 1 cycle.
  - Expect 3 strobes and o_wr_count = 3.
  - Expect no strobe while req stays high.
- Bad address: addr = 9'd400.
  - Expect no strobe and o_bad_addr_err = 1; ack still asserted.
  - Expect o_wr_count unchanged; i_clear_err clears the flag.
- Stuck request with TIMEOUT_CYCLES = 8: req held for 20 cycles.
  - Expect o_timeout_err set exactly 8 cycles after WAIT_REL entry and only one strobe.
  - Simultaneous i_clear_err at the set cycle leaves the flag = 1.
- Reset in STROBE/WAIT_REL: assert i_reset = 0 asynchronously mid-cycle.
  - Expect all outputs 0 immediately and o_busy = 0.
  - After reset release with req still high, a new transaction starts.
- Counter wrap: preload via 65536 writes (or NB_WR_COUNT = 4, 16 writes).
  - Expect o_wr_count to wrap to 0.
